// File: rtl/reset_seq_pf_if.sv
// Reset sequencer domain-side bundle: control inputs, per-domain resets,
// ready acknowledges and status flags.
interface reset_seq_pf_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   FF_US_RESTORE;
    logic                   SW_RST_REQ;
    logic [NUM_DOMAINS-1:0] DOMAIN_READY;
    logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N;
    logic                   ALL_RELEASED;
    logic                   SEQ_BUSY;
    logic [NUM_DOMAINS-1:0] READY_ERR;

    modport master (
        input  FF_US_RESTORE,
        input  SW_RST_REQ,
        input  DOMAIN_READY,
        output DOMAIN_RESET_N,
        output ALL_RELEASED,
        output SEQ_BUSY,
        output READY_ERR
    );

    modport slave (
        output FF_US_RESTORE,
        output SW_RST_REQ,
        output DOMAIN_READY,
        input  DOMAIN_RESET_N,
        input  ALL_RELEASED,
        input  SEQ_BUSY,
        input  READY_ERR
    );
endinterface

// File: rtl/reset_seq_pf.sv
// Staged multi-domain reset release sequencer with stretch, gap and ready wait.
// Optional ready timeout enabled by defining RESET_SEQ_READY_TIMEOUT_EN.
module reset_seq_pf #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int READY_TIMEOUT  = 1024
) (
    input logic            CLK,
    input logic            INTERNAL_RST,
    reset_seq_pf_if.master bus
);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [15:0] STR_LAST = 16'(STRETCH_CYCLES - 1);
    localparam logic [15:0] GAP_LAST =
        (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 ||
        STRETCH_CYCLES < 1 || STRETCH_CYCLES > 65535 ||
        GAP_CYCLES < 0 || GAP_CYCLES > 65535 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        READY_TIMEOUT < 1 || READY_TIMEOUT > 65535) begin : g_bad_param
        $error("reset_seq_pf: illegal parameter value");
    end

    typedef enum logic [2:0] {
        HOLD, STRETCH, RELEASE, WAIT_READY, GAP, RUN
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            cnt_q;
    logic [15:0]            cnt_d;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic                   all_rel_q;
    logic                   busy_q;
    logic                   sync_rise;
    logic                   ready_ok;
    logic                   tmo_hit;
    logic                   wr_done;

    assign sync_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign idx_d     = idx_q + IW'(1);
    // A domain still held by the sequencer cannot acknowledge.
    assign ready_ok  = bus.DOMAIN_READY[idx_q] & rst_n_q[idx_q];
    assign wr_done   = ready_ok | tmo_hit;

`ifdef RESET_SEQ_READY_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(READY_TIMEOUT - 1);
    logic [NUM_DOMAINS-1:0] err_q;
    assign tmo_hit       = ~ready_ok & (cnt_q == TMO_LAST);
    assign bus.READY_ERR = err_q;
`else
    assign tmo_hit       = 1'b0;
    assign bus.READY_ERR = '0;
`endif

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) sync_q <= '0;
        else               sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RESET_SEQ_READY_TIMEOUT_EN
            err_q     <= '0;
`endif
        end else if (bus.SW_RST_REQ && state_q != HOLD) begin
            state_q   <= STRETCH;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (sync_rise) begin
                        state_q <= STRETCH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                STRETCH: begin
                    if (cnt_q == STR_LAST) begin
                        rst_n_q[0] <= 1'b1;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= WAIT_READY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_READY: begin
                    if (wr_done) begin
`ifdef RESET_SEQ_READY_TIMEOUT_EN
                        if (tmo_hit) err_q[idx_q] <= 1'b1;
`endif
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= RUN;
                            all_rel_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else if (GAP_CYCLES == 0) begin
                            rst_n_q[idx_d] <= 1'b1;
                            idx_q          <= idx_d;
                        end else begin
                            state_q <= GAP;
                        end
                    end
`ifdef RESET_SEQ_READY_TIMEOUT_EN
                    else cnt_q <= cnt_d;
`endif
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_n_q[idx_d] <= 1'b1;
                        idx_q          <= idx_d;
                        cnt_q          <= '0;
                        state_q        <= WAIT_READY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN: ;
                default: state_q <= HOLD;
            endcase
        end
    end

    // Flash-freeze restore overrides outputs only; sequencer state is kept.
    assign bus.DOMAIN_RESET_N =
        rst_n_q | {NUM_DOMAINS{bus.FF_US_RESTORE}};
    assign bus.ALL_RELEASED = all_rel_q;
    assign bus.SEQ_BUSY     = busy_q;
endmodule

// File: tb/tb_reset_seq_pf.sv
// Directed bench for reset_seq_pf at default parameters.
module tb_reset_seq_pf;
    logic CLK = 1'b0;
    logic INTERNAL_RST;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    reset_seq_pf_if #(.NUM_DOMAINS(4)) bus ();

    reset_seq_pf dut (
        .CLK          (CLK),
        .INTERNAL_RST (INTERNAL_RST),
        .bus          (bus)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        edge_n++;
        #1;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] rn,
                           input logic ar, input logic bz);
        chk({tag, ".rstn"}, 32'(bus.DOMAIN_RESET_N), 32'(rn));
        chk({tag, ".all"},  32'(bus.ALL_RELEASED),   32'(ar));
        chk({tag, ".busy"}, 32'(bus.SEQ_BUSY),       32'(bz));
    endtask

    initial begin
        INTERNAL_RST      = 1'b0;
        bus.FF_US_RESTORE = 1'b0;
        bus.SW_RST_REQ    = 1'b0;
        bus.DOMAIN_READY  = 4'hF;
        #1;
        chk_out("reset", 4'h0, 1'b0, 1'b0);
        chk("reset.err", 32'(bus.READY_ERR), 32'h0);
        step();
        step();
        INTERNAL_RST = 1'b1;
        edge_n = 0;

        step_to(1);
        chk_out("e1", 4'h0, 1'b0, 1'b0);
        step_to(2);
        chk_out("e2", 4'h0, 1'b0, 1'b1);
        step_to(10);
        bus.FF_US_RESTORE = 1'b1;
        #1;
        chk("ff_on", 32'(bus.DOMAIN_RESET_N), 32'hF);
        step_to(12);
        bus.FF_US_RESTORE = 1'b0;
        #1;
        chk("ff_off", 32'(bus.DOMAIN_RESET_N), 32'h0);
        step_to(17);
        chk_out("e17", 4'h0, 1'b0, 1'b1);
        step_to(18);
        chk_out("e18", 4'h1, 1'b0, 1'b1);
        step_to(26);
        chk("e26", 32'(bus.DOMAIN_RESET_N), 32'h1);
        step_to(27);
        chk("e27", 32'(bus.DOMAIN_RESET_N), 32'h3);
        step_to(35);
        chk("e35", 32'(bus.DOMAIN_RESET_N), 32'h3);
        step_to(36);
        chk("e36", 32'(bus.DOMAIN_RESET_N), 32'h7);
        step_to(45);
        chk_out("e45", 4'hF, 1'b0, 1'b1);
        step_to(46);
        chk_out("e46", 4'hF, 1'b1, 1'b0);

        step_to(50);
        bus.SW_RST_REQ = 1'b1;
        step_to(51);
        bus.SW_RST_REQ = 1'b0;
        bus.DOMAIN_READY = 4'b1101;
        chk_out("sw51", 4'h0, 1'b0, 1'b1);
        step_to(66);
        chk("sw66", 32'(bus.DOMAIN_RESET_N), 32'h0);
        step_to(67);
        chk("sw67", 32'(bus.DOMAIN_RESET_N), 32'h1);
        chk("sw.err", 32'(bus.READY_ERR), 32'h0);

        step_to(75);
        chk("st75", 32'(bus.DOMAIN_RESET_N), 32'h1);
        step_to(76);
        chk("st76", 32'(bus.DOMAIN_RESET_N), 32'h3);
        step_to(106);
        chk_out("st106", 4'h3, 1'b0, 1'b1);
`ifdef RESET_SEQ_READY_TIMEOUT_EN
        step_to(1099);
        chk("tmo1099", 32'(bus.READY_ERR), 32'h0);
        step_to(1100);
        chk("tmo1100", 32'(bus.READY_ERR), 32'h2);
`else
        chk("st.err", 32'(bus.READY_ERR), 32'h0);
`endif

        #2;
        INTERNAL_RST = 1'b0;
        #1;
        chk_out("arst", 4'h0, 1'b0, 1'b0);
        chk("arst.err", 32'(bus.READY_ERR), 32'h0);
        bus.FF_US_RESTORE = 1'b1;
        #1;
        chk("arst.ff", 32'(bus.DOMAIN_RESET_N), 32'hF);
        bus.FF_US_RESTORE = 1'b0;
        bus.DOMAIN_READY  = 4'hF;
        INTERNAL_RST      = 1'b1;
        edge_n = 0;

        step_to(2);
        chk("r2.busy", 32'(bus.SEQ_BUSY), 32'h1);
        step_to(17);
        chk("r17", 32'(bus.DOMAIN_RESET_N), 32'h0);
        step_to(18);
        chk("r18", 32'(bus.DOMAIN_RESET_N), 32'h1);
        step_to(27);
        chk("r27", 32'(bus.DOMAIN_RESET_N), 32'h3);
        step_to(36);
        chk("r36", 32'(bus.DOMAIN_RESET_N), 32'h7);
        step_to(45);
        chk("r45", 32'(bus.DOMAIN_RESET_N), 32'hF);
        step_to(46);
        chk_out("r46", 4'hF, 1'b1, 1'b0);

        step_to(50);
        bus.SW_RST_REQ = 1'b1;
        step_to(55);
        chk_out("swh55", 4'h0, 1'b0, 1'b1);
        bus.SW_RST_REQ = 1'b0;
        step_to(70);
        chk("swh70", 32'(bus.DOMAIN_RESET_N), 32'h0);
        step_to(71);
        chk("swh71", 32'(bus.DOMAIN_RESET_N), 32'h1);
        chk("swh.err", 32'(bus.READY_ERR), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reset_seq_pf.md
RESET_SEQ_PF -- requirements
Module: reset_seq_pf

Interface
REQ-001 Parameter NUM_DOMAINS, 4: number of reset domains, legal 1..8.
REQ-002 Parameter STRETCH_CYCLES, 16: reset stretch length in CLK cycles, legal 1..65535.
REQ-003 Parameter GAP_CYCLES, 8: spacing between consecutive domain releases, legal 0..65535.
REQ-004 Parameter SYNC_STAGES, 2: reset-deassertion synchroniser depth, legal 2..4.
REQ-005 Parameter READY_TIMEOUT, 1024: per-domain ready wait limit in cycles, legal 1..65535; used only with the Configuration macro.
REQ-006 CLK  in  1  sequencer clock.
REQ-007 INTERNAL_RST  in  1  asynchronous, active-low reset; assertion immediate, deassertion synchronised internally.
REQ-008 FF_US_RESTORE  in  1  flash-freeze restore; high forces all domains out of reset.
REQ-009 SW_RST_REQ  in  1  synchronous software reset request, sampled each edge.
REQ-010 DOMAIN_READY  in  NUM_DOMAINS  per-domain "domain alive" acknowledge.
REQ-011 DOMAIN_RESET_N  out  NUM_DOMAINS  per-domain active-low reset.
REQ-012 ALL_RELEASED  out  1  all domains released and acknowledged.
REQ-013 SEQ_BUSY  out  1  sequence in progress.
REQ-014 READY_ERR  out  NUM_DOMAINS  sticky per-domain ready-timeout flags.

Function
REQ-015 FSM states SHALL be HOLD, STRETCH, RELEASE, WAIT_READY, GAP, RUN.
REQ-016 HOLD -> STRETCH on the edge at which the synchronised reset deasserts (SYNC_STAGES edges after INTERNAL_RST rises).
REQ-017 STRETCH SHALL count STRETCH_CYCLES edges, then release domain 0 (DOMAIN_RESET_N[0] rises) and enter WAIT_READY for index 0.
REQ-018 WAIT_READY(i): on the first edge sampling DOMAIN_READY[i]=1, go to GAP if i<NUM_DOMAINS-1, else to RUN with ALL_RELEASED=1 on that edge.
REQ-019 GAP SHALL count GAP_CYCLES edges, then release domain i+1 and enter WAIT_READY(i+1); GAP_CYCLES=0 releases i+1 on the edge leaving WAIT_READY.
REQ-020 Domains SHALL be released strictly in ascending index order; a released domain SHALL stay released until INTERNAL_RST or SW_RST_REQ.
REQ-021 SW_RST_REQ sampled high in any state except HOLD: next edge drives all DOMAIN_RESET_N low, ALL_RELEASED low, SEQ_BUSY high, enters STRETCH with counter cleared.
REQ-022 SW_RST_REQ held high SHALL keep the FSM in STRETCH at count 0; the sequence restarts on the first edge it is sampled low.
REQ-023 SW_RST_REQ coincident with a ready or counter terminal event SHALL win.
REQ-024 SEQ_BUSY SHALL be high in STRETCH, RELEASE, WAIT_READY and GAP, low in HOLD and RUN.
REQ-025 FF_US_RESTORE=1 SHALL combinationally force every DOMAIN_RESET_N high without altering FSM state; outputs follow the FSM again once it falls.
REQ-026 DOMAIN_READY[i] SHALL be ignored while DOMAIN_RESET_N[i] is low from the FSM.
REQ-027 Counters SHALL be 16 bits, saturating; no wrap-around is permitted.

Reset
REQ-028 INTERNAL_RST low SHALL asynchronously force: FSM HOLD, all DOMAIN_RESET_N=0, ALL_RELEASED=0, SEQ_BUSY=0, READY_ERR=0, counters 0, synchroniser cleared.
REQ-029 INTERNAL_RST asserted mid-sequence or in RUN SHALL abort with the values of REQ-028, regardless of FF_US_RESTORE; FF_US_RESTORE override still applies to DOMAIN_RESET_N.
REQ-030 READY_ERR SHALL clear only on INTERNAL_RST, not on SW_RST_REQ.

Configuration
REQ-031 Macro RESET_SEQ_READY_TIMEOUT_EN defined: WAIT_READY(i) lasting READY_TIMEOUT edges without ready SHALL set READY_ERR[i] and proceed as if ready was sampled on that edge.
REQ-032 Macro undefined: WAIT_READY waits indefinitely; READY_ERR tied to 0; no timeout counter is built.

Verification
REQ-033 Defaults, DOMAIN_READY=4'hF, INTERNAL_RST rises before edge 1 -> DOMAIN_RESET_N bits rise at edges 18, 27, 36, 45; ALL_RELEASED and SEQ_BUSY low at edge 46.
REQ-034 Defaults, DOMAIN_READY[1] held low -> domain 1 released at 27, domains 2-3 stay low, SEQ_BUSY stays high; READY_ERR[1] sets at edge 1051 only with macro defined.
REQ-035 In RUN, SW_RST_REQ 1-cycle pulse at edge k -> all DOMAIN_RESET_N low after edge k+1, domain 0 re-released at edge k+17; READY_ERR unchanged.
REQ-036 INTERNAL_RST pulsed low between edges 30 and 31 -> all outputs 0 immediately, no CLK needed; restart identical to REQ-033 timing.
REQ-037 FF_US_RESTORE=1 during STRETCH -> DOMAIN_RESET_N=4'hF immediately; on drop, returns to FSM values, sequence timing unchanged.
